// File: rtl/seven_seg_ctrl_if.sv
// Write/load bus and display outputs of the seven-segment controller.
// The controller drives slave-side outputs; the peripheral side uses master.
interface seven_seg_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  localparam int unsigned AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                      wr_en_i;
  logic [AW-1:0]             wr_addr_i;
  logic [7:0]                wr_data_i;
  logic                      ld_i;
  logic [4*NUM_DIGITS-1:0]   ld_value_i;
  logic [7*NUM_DIGITS-1:0]   hex_o;
  logic                      blink_phase_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, ld_i, ld_value_i,
    input  hex_o, blink_phase_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, ld_i, ld_value_i,
    output hex_o, blink_phase_o
  );
endinterface

// File: rtl/seven_seg_ctrl.sv
// Registered seven-segment display controller with per-digit value/blank/blink
// register file, full hex decode and a free-running blink prescaler.
// Optional macro SEVEN_SEG_LZB_EN adds leading-zero blanking at the decode stage.
module seven_seg_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input logic             clk_i,
  input logic             rst_ni,
  seven_seg_ctrl_if.slave bus
);
  localparam int unsigned AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CntMax = CW'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0][3:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]      blank_q, blank_d;
  logic [NUM_DIGITS-1:0]      blink_q, blink_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       phase_q, phase_d;
  logic [NUM_DIGITS-1:0][6:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]      supp;

  logic unused_wr_data;
  assign unused_wr_data = ^bus.wr_data_i[7:6];

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Register file next state: bulk load first, then a single write overrides its digit.
  always_comb begin
    val_d   = val_q;
    blank_d = blank_q;
    blink_d = blink_q;
    if (bus.ld_i) begin
      val_d   = bus.ld_value_i;
      blank_d = '0;
      blink_d = '0;
    end
    if (bus.wr_en_i) begin
      // Out-of-range addresses match no digit and are dropped.
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (bus.wr_addr_i == AW'(k)) begin
          val_d[k]   = bus.wr_data_i[3:0];
          blank_d[k] = bus.wr_data_i[4];
          blink_d[k] = bus.wr_data_i[5];
        end
      end
    end
  end

  // Blink prescaler: wraps at BLINK_DIV-1 and flips the phase on each wrap.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CntMax) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  // Leading-zero suppression scanned from the top digit; digit 0 always shows.
  always_comb begin
    logic lead;
    lead = 1'b1;
    supp = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if ((val_q[k] != 4'd0) || blank_q[k]) lead = 1'b0;
      supp[k] = lead && (k != 0);
    end
  end
`else
  assign supp = '0;
`endif

  // Per-digit segment pattern: blank, then blink-off phase, then decoded value.
  always_comb begin
    hex_d = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (blank_q[k] || (blink_q[k] && !phase_q) || supp[k]) begin
        hex_d[k] = 7'h7F;
      end else begin
        hex_d[k] = seg_decode(val_q[k]);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q   <= '0;
      blank_q <= '1;
      blink_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      hex_q   <= {NUM_DIGITS{7'h7F}};
    end else begin
      val_q   <= val_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
    end
  end

  assign bus.hex_o         = hex_q;
  assign bus.blink_phase_o = phase_q;

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Self-checking bench for seven_seg_ctrl: directed cases plus randomized traffic
// compared every cycle against a behavioural display model.
module tb_seven_seg_ctrl;
  localparam int unsigned N  = 6;
  localparam int unsigned BD = 4;
  localparam int unsigned AW = 3;
  localparam int unsigned LW = 4 * N;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  logic chk_on = 1'b0;

  always #5 clk_i = ~clk_i;

  seven_seg_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_ctrl #(
    .NUM_DIGITS(N),
    .BLINK_DIV (BD)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  logic [3:0]     m_val   [N];
  logic           m_blank [N];
  logic           m_blink [N];
  int             m_edges;
  logic [7*N-1:0] exp_hex;
  logic           exp_phase;

  // Phase after e edges since reset: starts lit, flips every BD edges.
  function automatic logic phase_at(input int e);
    return ((e / BD) % 2) == 0;
  endfunction

  function automatic logic [7*N-1:0] model_hex();
    logic [7*N-1:0] r;
    logic           ph;
    logic           lz;
`ifdef SEVEN_SEG_LZB_EN
    int             h;
    h = -1;
    for (int k = 0; k < N; k++) if (m_val[k] != 0 || m_blank[k]) h = k;
`endif
    r  = '0;
    ph = phase_at(m_edges);
    for (int k = 0; k < N; k++) begin
      lz = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
      lz = (k > h) && (k != 0);
`endif
      if (m_blank[k])                 r[7*k +: 7] = 7'h7F;
      else if (m_blink[k] && !ph)     r[7*k +: 7] = 7'h7F;
      else if (lz)                    r[7*k +: 7] = 7'h7F;
      else                            r[7*k +: 7] = seg_tbl[m_val[k]];
    end
    return r;
  endfunction

  // Model update: outputs reflect pre-edge state, register file takes this cycle's inputs.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N; k++) begin
        m_val[k]   <= 4'd0;
        m_blank[k] <= 1'b1;
        m_blink[k] <= 1'b0;
      end
      m_edges   <= 0;
      exp_hex   <= {N{7'h7F}};
      exp_phase <= 1'b1;
    end else begin
      exp_hex   <= model_hex();
      exp_phase <= phase_at(m_edges + 1);
      m_edges   <= m_edges + 1;
      if (bus.ld_i) begin
        for (int k = 0; k < N; k++) begin
          m_val[k]   <= bus.ld_value_i[4*k +: 4];
          m_blank[k] <= 1'b0;
          m_blink[k] <= 1'b0;
        end
      end
      if (bus.wr_en_i) begin
        for (int k = 0; k < N; k++) begin
          if (int'(bus.wr_addr_i) == k) begin
            m_val[k]   <= bus.wr_data_i[3:0];
            m_blank[k] <= bus.wr_data_i[4];
            m_blink[k] <= bus.wr_data_i[5];
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (chk_on) begin
      check("hex_o_model", 64'(bus.hex_o), 64'(exp_hex));
      check("phase_model", 64'(bus.blink_phase_o), 64'(exp_phase));
    end
  end

  task automatic clear_inputs();
    bus.wr_en_i    = 1'b0;
    bus.wr_addr_i  = '0;
    bus.wr_data_i  = '0;
    bus.ld_i       = 1'b0;
    bus.ld_value_i = '0;
  endtask

  // Presents one write for a cycle; caller is just after a negedge.
  task automatic do_write(input int addr, input logic [7:0] data);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = AW'(addr);
    bus.wr_data_i = data;
    @(negedge clk_i);
    bus.wr_en_i   = 1'b0;
  endtask

  task automatic do_load(input logic [LW-1:0] v);
    bus.ld_i       = 1'b1;
    bus.ld_value_i = v;
    @(negedge clk_i);
    bus.ld_i       = 1'b0;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_en_i    = 1'($urandom_range(0, 1));
      bus.wr_addr_i  = AW'($urandom_range(0, 7));
      bus.wr_data_i  = 8'($urandom());
      bus.wr_data_i[4] = ($urandom_range(0, 3) == 0);
      bus.wr_data_i[5] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) bus.wr_data_i[3:0] = 4'd0;
      bus.ld_i       = ($urandom_range(0, 7) == 0);
      bus.ld_value_i = LW'($urandom()) & LW'($urandom()) & LW'($urandom());
      @(negedge clk_i);
    end
    clear_inputs();
  endtask

  int         n_dark;
  logic [6:0] d0;

  initial begin
    clear_inputs();
    #1 rst_ni = 1'b0;
    #1 chk_on = 1'b1;

    // Reset state held, then released and idle.
    repeat (3) @(negedge clk_i);
    check("reset_hex", 64'(bus.hex_o), 64'({N{7'h7F}}));
    check("reset_phase", 64'(bus.blink_phase_o), 64'd1);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("idle_hex", 64'(bus.hex_o), 64'({N{7'h7F}}));
    check("idle_phase", 64'(bus.blink_phase_o), 64'd1);

    // Decode sweep on digit 3.
    for (int v = 0; v < 16; v++) begin
      do_write(3, {4'b0000, 4'(v)});
      @(negedge clk_i);
      check("sweep_digit3", 64'(bus.hex_o[27:21]), 64'(seg_tbl[v]));
    end

    // Bulk load colliding with a write to digit 2.
    bus.ld_i       = 1'b1;
    bus.ld_value_i = 24'h543210;
    bus.wr_en_i    = 1'b1;
    bus.wr_addr_i  = 3'd2;
    bus.wr_data_i  = 8'h09;
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
    check("bulk_collide", 64'(bus.hex_o), 64'({7'h12, 7'h19, 7'h30, 7'h10, 7'h79, 7'h40}));

    // Out-of-range writes leave the display untouched.
    do_write(7, 8'h08);
    @(negedge clk_i);
    check("oor_addr7", 64'(bus.hex_o), 64'({7'h12, 7'h19, 7'h30, 7'h10, 7'h79, 7'h40}));
    do_write(6, 8'h10);
    @(negedge clk_i);
    check("oor_addr6", 64'(bus.hex_o), 64'({7'h12, 7'h19, 7'h30, 7'h10, 7'h79, 7'h40}));

    // Blink on digit 0 (value 5); digit 1 stays steady.
    do_write(0, 8'h25);
    @(negedge clk_i);
    n_dark = 0;
    repeat (16) begin
      d0 = bus.hex_o[6:0];
      if (d0 == 7'h7F) n_dark++;
      check("blink_d0_valid", 64'((d0 == 7'h12) || (d0 == 7'h7F)), 64'd1);
      check("blink_d1_steady", 64'(bus.hex_o[13:7]), 64'h79);
      @(negedge clk_i);
    end
    check("blink_dark_count", 64'(n_dark), 64'd8);

    // Leading zeros.
    do_load(24'h000105);
    @(negedge clk_i);
`ifdef SEVEN_SEG_LZB_EN
    check("lzb_0105", 64'(bus.hex_o), 64'({7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h12}));
`else
    check("lzb_0105", 64'(bus.hex_o), 64'({7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h12}));
`endif
    do_load(24'h000000);
    @(negedge clk_i);
`ifdef SEVEN_SEG_LZB_EN
    check("lzb_zero", 64'(bus.hex_o), 64'({{5{7'h7F}}, 7'h40}));
`else
    check("lzb_zero", 64'(bus.hex_o), 64'({N{7'h40}}));
`endif

    // Randomized traffic, mid-run reset, more traffic.
    random_cycles(200);
    #2 rst_ni = 1'b0;
    #1;
    check("midreset_hex", 64'(bus.hex_o), 64'({N{7'h7F}}));
    check("midreset_phase", 64'(bus.blink_phase_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    random_cycles(200);

    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
